id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage of the 5-stage MIPS pipeline; sits directly upstream of the ALU and feeds its input1, input2 and AluCtrl.
- Captures decoded fields from ID and generates the 4-bit ALU control code.
- Resolves EX/MEM and MEM/WB forwarding and detects load-use hazards.
- Outputs are stable from the rising edge, so the ALU's negedge sampling sees settled values.

Parameters:
- W, 32, datapath width.
- RW, 5, register-index width.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- stall_in  in  1  external hold (e.g. memory wait); freezes all stage registers.
- flush_in  in  1  branch/jump squash; next cycle is a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_rs_data, id_rt_data  in  W  register-file read data.
- id_imm  in  W  sign- or zero-extended immediate.
- id_rs, id_rt, id_rd  in  RW  register indices.
- id_shamt  in  5  shift amount.
- id_alu_op  in  2  00 add, 01 sub, 10 R-type, 11 ori.
- id_funct  in  6  R-type function field.
- id_alu_src  in  1  1 selects the immediate for input2.
- id_reg_dst  in  1  1 selects rd as destination, 0 selects rt.
- id_uses_rt  in  1  instruction reads rt.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits.
- exmem_reg_write  in  1, exmem_rd  in  RW, exmem_result  in  W  forwarding source 1.
- memwb_reg_write  in  1, memwb_rd  in  RW, memwb_data  in  W  forwarding source 2.
- input1, input2  out  W  ALU operands (combinational from registered state and forwarding).
- AluCtrl  out  4  registered ALU control.
- ex_store_data  out  W  forwarded rt value for sw.
- ex_dest  out  RW  destination register.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered.
- illegal_funct  out  1  registered; R-type funct not supported.
- load_use_stall  out  1  combinational; upstream must hold PC and IF/ID when high.

Behaviour:
- Reset: all registers clear; ex_valid=0, every control output 0, AluCtrl=0000, ex_dest=0, illegal_funct=0; input1/input2 resolve to 0.
- Update priority per posedge: Reset > flush_in > stall_in > load_use_stall > capture.
  - flush_in: load a bubble (valid and all control bits 0, AluCtrl=0000, data 0).
  - stall_in: hold every register.
  - load_use_stall: load a bubble.
  - capture: register all id_* fields; register control bits ANDed with id_valid.
- load_use_stall is 1 when all of the following hold:
  - ex_valid && ex_mem_read && ex_dest!=0;
  - id_valid;
  - ex_dest==id_rs, or (id_uses_rt && ex_dest==id_rt).
  - It is forced to 0 while flush_in=1.
- ex_dest = reg_dst ? rd : rt, computed at capture.
- AluCtrl decode at capture:
  - alu_op 00 -> 0010; 01 -> 0110; 11 -> 0001.
  - alu_op 10, by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 000000 -> 1100.
  - Any other funct -> 1111 with illegal_funct=1.
- Forward function fwd(idx, regval):
  - exmem_reg_write && exmem_rd!=0 && exmem_rd==idx -> exmem_result;
  - else memwb_reg_write && memwb_rd!=0 && memwb_rd==idx -> memwb_data;
  - else regval.
  - EX/MEM always beats MEM/WB; register 0 is never forwarded.
- Operand select:
  - input1 = fwd(rs) normally.
  - For sll (AluCtrl 1100): input1 = fwd(rt) and input2 = {27'b0, shamt}.
  - Otherwise input2 = alu_src ? imm : fwd(rt).
- ex_store_data = fwd(rt) always.
- Latency: one cycle from ID capture to the EX outputs.
- Reset asserted mid-stall or together with flush_in: the reset result wins.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- When defined, adds two 32-bit outputs:
  - perf_bubbles: counts cycles in which a bubble was loaded due to flush_in or load_use_stall.
  - perf_holds: counts stall_in hold cycles.
  - Both counters clear on Reset and wrap modulo 2^32.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- R-type add, id_rs_data=5, id_rt_data=7, funct 100000, no hazards -> next cycle input1=5, input2=7, AluCtrl=0010, ex_reg_write=1.
- Back-to-back dependency: exmem_rd=8, exmem_result=0x11; memwb_rd=8, memwb_data=0x22; ex rs=8 -> input1=0x11. Repeat with exmem_rd=0 -> input1=0x22.
- lw $t0 in EX, then ID add using rs=$t0 -> load_use_stall=1 for one cycle. Next EX is a bubble (ex_valid=0, controls 0); the add captures the cycle after.
- sll with rt data 0x3, shamt=4 -> input1=3, input2=4, AluCtrl=1100.
- stall_in held 3 cycles during a valid sub -> outputs unchanged. flush_in asserted together with stall_in -> bubble loaded.
- funct 111111 with alu_op 10 -> AluCtrl=1111, illegal_funct=1. Reset asserted next -> all outputs 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and operand-select stage of the 5-stage MIPS pipeline.
// Captures the decoded instruction, generates the 4-bit ALU control code and
// resolves EX/MEM and MEM/WB forwarding for the ALU operands and store data.
// It also flags load-use hazards back to IF/ID.
//
// Optional build macro: IDEX_PERF_CNT_EN adds the perf_bubbles/perf_holds
// counters. Without it those ports do not exist and nothing else changes.
//
// Update priority on each rising edge:
//   Reset > flush_in > stall_in > load_use_stall > capture
// No FSM: the stage is a single register bank with a priority-selected next state.
module id_ex_stage #(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          stall_in,
  input  logic          flush_in,
  input  logic          id_valid,
  input  logic [W-1:0]  id_rs_data,
  input  logic [W-1:0]  id_rt_data,
  input  logic [W-1:0]  id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [4:0]    id_shamt,
  input  logic [1:0]    id_alu_op,
  input  logic [5:0]    id_funct,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_uses_rt,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [W-1:0]  memwb_data,
  output logic [W-1:0]  input1,
  output logic [W-1:0]  input2,
  output logic [3:0]    AluCtrl,
  output logic [W-1:0]  ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          illegal_funct,
  output logic          load_use_stall
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]   perf_bubbles,
  output logic [31:0]   perf_holds
`endif
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_SLL = 4'b1100;
  localparam logic [3:0] CTRL_BAD = 4'b1111;

  // Everything held between ID and EX. An all-zero value is a bubble: no valid
  // instruction, no side-effecting control, register 0 as operands.
  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          alu_src;
    logic          illegal;
    logic [3:0]    alu_ctrl;
    logic [RW-1:0] dest;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [4:0]    shamt;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic [W-1:0]  imm;
  } ex_regs_t;

  ex_regs_t ex_q;
  ex_regs_t ex_d;

  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  logic [W-1:0] fwd_rs;
  logic [W-1:0] fwd_rt;

  // ALU control decode of the instruction currently in ID.
  always_comb begin
    dec_ctrl    = CTRL_ADD;
    dec_illegal = 1'b0;
    case (id_alu_op)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b11: dec_ctrl = CTRL_OR;
      default: begin
        case (id_funct)
          6'b100000: dec_ctrl = CTRL_ADD;
          6'b100010: dec_ctrl = CTRL_SUB;
          6'b100100: dec_ctrl = CTRL_AND;
          6'b100101: dec_ctrl = CTRL_OR;
          6'b101010: dec_ctrl = CTRL_SLT;
          6'b000000: dec_ctrl = CTRL_SLL;
          default: begin
            dec_ctrl    = CTRL_BAD;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // A flush squashes ID anyway, so the hazard is meaningless then.
  always_comb begin
    load_use_stall = 1'b0;
    if (ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) && id_valid && !flush_in) begin
      if ((ex_q.dest == id_rs) || (id_uses_rt && (ex_q.dest == id_rt))) begin
        load_use_stall = 1'b1;
      end
    end
  end

  // Next-state selection in priority order; Reset is applied in the register.
  always_comb begin
    ex_d = ex_q;
    if (flush_in) begin
      ex_d = '0;
    end else if (stall_in) begin
      ex_d = ex_q;
    end else if (load_use_stall) begin
      ex_d = '0;
    end else begin
      ex_d.valid      = id_valid;
      ex_d.reg_write  = id_reg_write  & id_valid;
      ex_d.mem_read   = id_mem_read   & id_valid;
      ex_d.mem_write  = id_mem_write  & id_valid;
      ex_d.mem_to_reg = id_mem_to_reg & id_valid;
      ex_d.illegal    = dec_illegal   & id_valid;
      ex_d.alu_src    = id_alu_src;
      ex_d.alu_ctrl   = dec_ctrl;
      ex_d.dest       = id_reg_dst ? id_rd : id_rt;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.shamt      = id_shamt;
      ex_d.rs_data    = id_rs_data;
      ex_d.rt_data    = id_rt_data;
      ex_d.imm        = id_imm;
    end
  end

  // Stage register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Forwarding for rs: EX/MEM beats MEM/WB, register 0 never forwarded.
  always_comb begin
    fwd_rs = ex_q.rs_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_q.rs)) begin
      fwd_rs = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_q.rs)) begin
      fwd_rs = memwb_data;
    end
  end

  // Forwarding for rt, same rules as rs.
  always_comb begin
    fwd_rt = ex_q.rt_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_q.rt)) begin
      fwd_rt = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_q.rt)) begin
      fwd_rt = memwb_data;
    end
  end

  // Operand select: sll shifts rt by shamt, others use rs and rt/immediate.
  always_comb begin
    input1 = fwd_rs;
    input2 = ex_q.alu_src ? ex_q.imm : fwd_rt;
    if (ex_q.alu_ctrl == CTRL_SLL) begin
      input1 = fwd_rt;
      input2 = {{(W-5){1'b0}}, ex_q.shamt};
    end
  end

  assign ex_store_data = fwd_rt;
  assign AluCtrl       = ex_q.alu_ctrl;
  assign ex_dest       = ex_q.dest;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign illegal_funct = ex_q.illegal;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubbles_q, bubbles_d;
  logic [31:0] holds_q, holds_d;

  // A bubble is loaded by flush, or by a load-use hazard that stall_in does not override.
  always_comb begin
    bubbles_d = bubbles_q;
    holds_d   = holds_q;
    if (flush_in || (!stall_in && load_use_stall)) begin
      bubbles_d = bubbles_q + 32'd1;
    end
    if (stall_in && !flush_in) begin
      holds_d = holds_q + 32'd1;
    end
  end

  // Event counters, wrapping naturally.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bubbles_q <= '0;
      holds_q   <= '0;
    end else begin
      bubbles_q <= bubbles_d;
      holds_q   <= holds_d;
    end
  end

  assign perf_bubbles = bubbles_q;
  assign perf_holds   = holds_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. Each driver step sets the inputs for one
// cycle and pushes the outputs expected at that cycle's falling edge; a
// separate monitor pops and compares at every falling edge.
module tb_id_ex_stage;
  localparam int W  = 32;
  localparam int RW = 5;

  logic          Clk = 1'b0;
  logic          Reset, stall_in, flush_in, id_valid;
  logic [W-1:0]  id_rs_data, id_rt_data, id_imm;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [4:0]    id_shamt;
  logic [1:0]    id_alu_op;
  logic [5:0]    id_funct;
  logic          id_alu_src, id_reg_dst, id_uses_rt;
  logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic          exmem_reg_write, memwb_reg_write;
  logic [RW-1:0] exmem_rd, memwb_rd;
  logic [W-1:0]  exmem_result, memwb_data;
  logic [W-1:0]  input1, input2, ex_store_data;
  logic [3:0]    AluCtrl;
  logic [RW-1:0] ex_dest;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic          illegal_funct, load_use_stall;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0]   perf_bubbles, perf_holds;
`endif

  typedef struct packed {
    logic        v, rw, mr, mw, m2r;
    logic [4:0]  dest;
    logic [3:0]  ctrl;
    logic        ill;
    logic [31:0] in1, in2, st;
    logic        lus;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_mis = 0;

  id_ex_stage #(.W(W), .RW(RW)) dut (
    .Clk(Clk), .Reset(Reset), .stall_in(stall_in), .flush_in(flush_in),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .input1(input1), .input2(input2), .AluCtrl(AluCtrl), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .illegal_funct(illegal_funct), .load_use_stall(load_use_stall)
`ifdef IDEX_PERF_CNT_EN
    , .perf_bubbles(perf_bubbles), .perf_holds(perf_holds)
`endif
  );

  // Clock
  always #5 Clk = ~Clk;

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_id();
    id_valid = 0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0; id_alu_op = 2'b00;
    id_funct = '0; id_alu_src = 0; id_reg_dst = 0; id_uses_rt = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
  endtask

  task automatic clr_fwd();
    exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 0; memwb_rd = '0; memwb_data = '0;
  endtask

  task automatic set_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [5:0] funct, input logic [4:0] shamt);
    clr_id();
    id_valid = 1; id_alu_op = 2'b10; id_reg_dst = 1; id_uses_rt = 1; id_reg_write = 1;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_funct = funct; id_shamt = shamt;
  endtask

  task automatic push(input logic v, input logic rw, input logic mr, input logic mw,
                      input logic m2r, input logic [4:0] dest, input logic [3:0] ctrl,
                      input logic ill, input logic [31:0] in1, input logic [31:0] in2,
                      input logic [31:0] st, input logic lus);
    exp_t e;
    e = '{v: v, rw: rw, mr: mr, mw: mw, m2r: m2r, dest: dest, ctrl: ctrl, ill: ill,
          in1: in1, in2: in2, st: st, lus: lus};
    exp_q.push_back(EW'(e));
  endtask

  task automatic push_zero(input logic [3:0] ctrl);
    push(0, 0, 0, 0, 0, 5'd0, ctrl, 0, 32'h0, 32'h0, 32'h0, 0);
  endtask

  // Scoreboard monitor: compares DUT outputs at every falling edge with a pending expectation
  always @(negedge Clk) begin
    exp_t e;
    exp_t g;
    if (exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      g = '{v: ex_valid, rw: ex_reg_write, mr: ex_mem_read, mw: ex_mem_write,
            m2r: ex_mem_to_reg, dest: ex_dest, ctrl: AluCtrl, ill: illegal_funct,
            in1: input1, in2: input2, st: ex_store_data, lus: load_use_stall};
      n_vec++;
      if (g !== e) begin
        n_mis++;
        $display("FAIL vec%0d: got v=%b rw=%b mr=%b mw=%b m2r=%b dest=%0d ctrl=%b ill=%b in1=%h in2=%h st=%h lus=%b | exp v=%b rw=%b mr=%b mw=%b m2r=%b dest=%0d ctrl=%b ill=%b in1=%h in2=%h st=%h lus=%b",
                 n_vec, g.v, g.rw, g.mr, g.mw, g.m2r, g.dest, g.ctrl, g.ill, g.in1, g.in2, g.st, g.lus,
                 e.v, e.rw, e.mr, e.mw, e.m2r, e.dest, e.ctrl, e.ill, e.in1, e.in2, e.st, e.lus);
      end
    end
  end

  // Directed stimulus
  initial begin
    Reset = 1; stall_in = 0; flush_in = 0;
    clr_id(); clr_fwd();
    tick();
    // Reset state
    push_zero(4'b0000);
    tick();
    // R-type add rs=1(5) rt=2(7) rd=3; outputs still from reset
    Reset = 0;
    set_r(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 6'b100000, 5'd0);
    push_zero(4'b0000);
    tick();
    // Add in EX
    clr_id();
    push(1, 1, 0, 0, 0, 5'd3, 4'b0010, 0, 32'd5, 32'd7, 32'd7, 0);
    tick();
    // Invalid, cleared ID captured: controls 0, alu_op 00 decodes to add
    set_r(5'd8, 5'd9, 5'd10, 32'h55, 32'h66, 6'b100010, 5'd0);
    push_zero(4'b0010);
    tick();
    // Sub in EX, held by stall_in; EX/MEM beats MEM/WB on rs=8
    clr_id();
    stall_in = 1;
    exmem_reg_write = 1; exmem_rd = 5'd8; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5'd8; memwb_data = 32'h22;
    push(1, 1, 0, 0, 0, 5'd10, 4'b0110, 0, 32'h11, 32'h66, 32'h66, 0);
    tick();
    // exmem_rd=0 is never forwarded, MEM/WB wins
    exmem_rd = 5'd0;
    push(1, 1, 0, 0, 0, 5'd10, 4'b0110, 0, 32'h22, 32'h66, 32'h66, 0);
    tick();
    // No EX/MEM write; MEM/WB now targets rt=9
    exmem_reg_write = 0; exmem_rd = 5'd8; memwb_rd = 5'd9;
    push(1, 1, 0, 0, 0, 5'd10, 4'b0110, 0, 32'h55, 32'h22, 32'h22, 0);
    tick();
    // Still holding after 3 stall cycles; flush together with stall loads a bubble
    clr_fwd();
    flush_in = 1;
    set_r(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 6'b100000, 5'd0);
    push(1, 1, 0, 0, 0, 5'd10, 4'b0110, 0, 32'h55, 32'h66, 32'h66, 0);
    tick();
    // Bubble from flush; present lw $8, 0x10($4)
    flush_in = 0; stall_in = 0;
    clr_id();
    id_valid = 1; id_alu_op = 2'b00; id_rs = 5'd4; id_rt = 5'd8; id_reg_dst = 0;
    id_alu_src = 1; id_imm = 32'h10; id_rs_data = 32'h100; id_rt_data = 32'h999;
    id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1;
    push_zero(4'b0000);
    tick();
    // lw in EX, add rs=$8 in ID -> load-use stall
    set_r(5'd8, 5'd2, 5'd5, 32'h1, 32'h2, 6'b100000, 5'd0);
    push(1, 1, 1, 0, 1, 5'd8, 4'b0010, 0, 32'h100, 32'h10, 32'h999, 1);
    tick();
    // Bubble in EX, add still in ID and captured this cycle
    push_zero(4'b0000);
    tick();
    // Add in EX; sll rt=3 shamt=4 in ID
    set_r(5'd0, 5'd3, 5'd6, 32'h77, 32'h3, 6'b000000, 5'd4);
    push(1, 1, 0, 0, 0, 5'd5, 4'b0010, 0, 32'h1, 32'h2, 32'h2, 0);
    tick();
    // sll in EX; illegal funct in ID
    set_r(5'd1, 5'd2, 5'd7, 32'hA, 32'hB, 6'b111111, 5'd0);
    push(1, 1, 0, 0, 0, 5'd6, 4'b1100, 0, 32'h3, 32'h4, 32'h3, 0);
    tick();
    // Illegal in EX; Reset together with flush and a valid ID instruction
    Reset = 1; flush_in = 1;
    set_r(5'd1, 5'd2, 5'd3, 32'd9, 32'd9, 6'b100000, 5'd0);
    push(1, 1, 0, 0, 0, 5'd7, 4'b1111, 1, 32'hA, 32'hB, 32'hB, 0);
    tick();
    // Reset result; ori $12, $2, 0xF0 in ID
    Reset = 0; flush_in = 0;
    clr_id();
    id_valid = 1; id_alu_op = 2'b11; id_alu_src = 1; id_rs = 5'd2; id_rt = 5'd12;
    id_imm = 32'hF0; id_rs_data = 32'h3; id_rt_data = 32'h44; id_reg_write = 1;
    push_zero(4'b0000);
    tick();
    // ori in EX; lw $9, 8($0) in ID
    clr_id();
    id_valid = 1; id_alu_op = 2'b00; id_rt = 5'd9; id_alu_src = 1; id_imm = 32'h8;
    id_rt_data = 32'h5; id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1;
    push(1, 1, 0, 0, 0, 5'd12, 4'b0001, 0, 32'h3, 32'hF0, 32'h44, 0);
    tick();
    // lw in EX; sw reading rt=$9 in ID -> load-use via rt
    clr_id();
    id_valid = 1; id_alu_op = 2'b00; id_rt = 5'd9; id_uses_rt = 1; id_alu_src = 1;
    id_imm = 32'h4; id_mem_write = 1;
    push(1, 1, 1, 0, 1, 5'd9, 4'b0010, 0, 32'h0, 32'h8, 32'h5, 1);
    tick();
    // Bubble from load-use
    clr_id();
    push_zero(4'b0000);
    tick();

    // Drain: bounded wait for the monitor to consume every expectation
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge Clk);
    if (exp_q.size() > 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
